// File: rtl/param_datapath_md.sv
// Single-bus CPU datapath: register file, PC/MDR/HI/LO/Y/Z on one shared bus, plus an ALU
// with single-cycle ops and iterative signed multiply/divide behind a start/busy/done handshake.

module pd_reg_cell #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (!clr)   q <= '0;
    else if (ld) q <= d;
  end
endmodule

module param_datapath_md #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [NREGS-1:0]    rf_in,
  input  logic [NREGS-1:0]    rf_out,
  input  logic                ba_out,
  input  logic                pc_in,
  input  logic                pc_out,
  input  logic                hi_in,
  input  logic                hi_out,
  input  logic                lo_in,
  input  logic                lo_out,
  input  logic                y_in,
  input  logic                inc_pc,
  input  logic                mdr_in,
  input  logic                mdr_read,
  input  logic                mdr_out,
  input  logic                zhi_out,
  input  logic                zlo_out,
  input  logic [DATA_W-1:0]   mdatain,
  input  logic [4:0]          alu_op,
  input  logic                alu_start,
  output logic                alu_busy,
  output logic                alu_done,
  output logic [DATA_W-1:0]   bus,
  output logic                bus_err,
  output logic [2*DATA_W-1:0] z
);
  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int NSRC  = NREGS + 6;
  localparam logic [4:0] OP_NOT = 5'h0A;
  localparam logic [4:0] OP_MUL = 5'h0B;
  localparam logic [4:0] OP_DIV = 5'h0C;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  logic [NREGS-1:0][DATA_W-1:0] rf_q;
  logic [DATA_W-1:0]            pc_q, mdr_q, hi_q, lo_q, y_q;
  logic [2*DATA_W-1:0]          z_q;
  logic [NSRC-1:0]              src_en;
  logic [DATA_W-1:0]            bus_or;

  genvar g;
  for (g = 0; g < NREGS; g++) begin : g_rf
    pd_reg_cell #(.W(DATA_W)) u_reg (
      .clk(clk), .clr(clr), .ld(rf_in[g]), .d(bus), .q(rf_q[g])
    );
  end

  // More than one bit set in the enable vector means a bus fight.
  assign src_en  = {rf_out, pc_out, hi_out, lo_out, mdr_out, zhi_out, zlo_out};
  assign bus_err = |(src_en & (src_en - NSRC'(1)));

  always_comb begin
    bus_or = '0;
    for (int i = 0; i < NREGS; i++)
      if (rf_out[i] && !(i == 0 && ba_out)) bus_or |= rf_q[i];
    if (pc_out)  bus_or |= pc_q;
    if (hi_out)  bus_or |= hi_q;
    if (lo_out)  bus_or |= lo_q;
    if (mdr_out) bus_or |= mdr_q;
    if (zhi_out) bus_or |= z_q[2*DATA_W-1:DATA_W];
    if (zlo_out) bus_or |= z_q[DATA_W-1:0];
  end

  assign bus = bus_err ? '0 : bus_or;

  always_ff @(posedge clk) begin
    if (!clr) begin
      pc_q  <= '0;
      mdr_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      y_q   <= '0;
    end else begin
      if (pc_in)       pc_q <= bus;
      else if (inc_pc) pc_q <= pc_q + DATA_W'(1);
      if (mdr_in) mdr_q <= mdr_read ? mdatain : bus;
      if (hi_in)  hi_q  <= bus;
      if (lo_in)  lo_q  <= bus;
      if (y_in)   y_q   <= bus;
    end
  end

  // ALU operands and single-cycle results
  logic [DATA_W-1:0] a_op, b_op, a_mag, b_mag, alu_r;
  logic [SH_W-1:0]   sh;
  logic              one_cyc, is_mul, is_div, div0, accept;

  assign a_op    = y_q;
  assign b_op    = bus;
  assign sh      = b_op[SH_W-1:0];
  assign a_mag   = a_op[DATA_W-1] ? -a_op : a_op;
  assign b_mag   = b_op[DATA_W-1] ? -b_op : b_op;
  assign one_cyc = alu_op <= OP_NOT;
  assign is_mul  = alu_op == OP_MUL;
  assign is_div  = alu_op == OP_DIV;
  assign div0    = is_div && (b_op == '0);

  always_comb begin
    alu_r = '0;
    case (alu_op)
      5'h00: alu_r = a_op + b_op;
      5'h01: alu_r = a_op - b_op;
      5'h02: alu_r = a_op & b_op;
      5'h03: alu_r = a_op | b_op;
      5'h04: alu_r = a_op >> sh;
      5'h05: alu_r = $signed(a_op) >>> sh;
      5'h06: alu_r = a_op << sh;
      5'h07: alu_r = (a_op >> sh) | (a_op << (DATA_W - int'(sh)));
      5'h08: alu_r = (a_op << sh) | (a_op >> (DATA_W - int'(sh)));
      5'h09: alu_r = -b_op;
      5'h0A: alu_r = ~b_op;
      default: alu_r = '0;
    endcase
  end

  // Mul/div engine: both work on magnitudes in one shared 2W+1 register, sign fixed at the end.
  // mul: p = {acc, multiplier}; div: p = {partial remainder, dividend/quotient}.
  state_t              state_q, state_d;
  logic [2*DATA_W:0]   p_q, p_mul, p_div;
  logic [DATA_W-1:0]   opd_q, quo, rem;
  logic [DATA_W:0]     mul_sum, r_sh, r_nxt;
  logic [2*DATA_W-1:0] prod, z_fin;
  logic [CNT_W-1:0]    cnt_q;
  logic                neg_q, neg_r_q, is_div_q, done_q, q_bit, last;

  assign accept = alu_start && (state_q != S_RUN);
  assign last   = cnt_q == CNT_W'(DATA_W);

  always_comb begin
    mul_sum = p_q[2*DATA_W:DATA_W] + {1'b0, {DATA_W{p_q[0]}} & opd_q};
    p_mul   = {1'b0, mul_sum, p_q[DATA_W-1:1]};
    r_sh    = {p_q[2*DATA_W-1:DATA_W], p_q[DATA_W-1]};
    q_bit   = r_sh >= {1'b0, opd_q};
    r_nxt   = q_bit ? r_sh - {1'b0, opd_q} : r_sh;
    p_div   = {r_nxt, p_q[DATA_W-2:0], q_bit};
    prod    = p_q[2*DATA_W-1:0];
    quo     = p_q[DATA_W-1:0];
    rem     = p_q[2*DATA_W-1:DATA_W];
    z_fin   = is_div_q ? {(neg_r_q ? -rem : rem), (neg_q ? -quo : quo)}
                       : (neg_q ? -prod : prod);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (last) state_d = S_FIN;
      default: state_d = (accept && (is_mul || (is_div && !div0))) ? S_RUN : S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      z_q      <= '0;
      p_q      <= '0;
      opd_q    <= '0;
      neg_q    <= 1'b0;
      neg_r_q  <= 1'b0;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        if (one_cyc) begin
          z_q    <= {{DATA_W{alu_r[DATA_W-1]}}, alu_r};
          done_q <= 1'b1;
        end else if (div0) begin
          z_q    <= {a_op, {DATA_W{1'b1}}};
          done_q <= 1'b1;
        end else if (is_mul || is_div) begin
          p_q      <= {{(DATA_W+1){1'b0}}, (is_div ? a_mag : b_mag)};
          opd_q    <= is_div ? b_mag : a_mag;
          neg_q    <= a_op[DATA_W-1] ^ b_op[DATA_W-1];
          neg_r_q  <= a_op[DATA_W-1];
          is_div_q <= is_div;
          cnt_q    <= '0;
        end else begin
          done_q <= 1'b1;
        end
      end else if (state_q == S_RUN) begin
        if (last) begin
          z_q    <= z_fin;
          done_q <= 1'b1;
        end else begin
          p_q   <= is_div_q ? p_div : p_mul;
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign alu_busy = state_q == S_RUN;
  assign alu_done = done_q;
  assign z        = z_q;

endmodule

// File: tb/tb_param_datapath_md.sv
// Directed + randomized bench for param_datapath_md; ALU results come from an arithmetic
// reference model (64-bit signed math, rotate via doubled word).

module tb_param_datapath_md;
  localparam int W = 32;
  localparam int N = 16;

  logic          clk = 1'b0;
  logic          clr;
  logic [N-1:0]  rf_in, rf_out;
  logic          ba_out, pc_in, pc_out, hi_in, hi_out, lo_in, lo_out, y_in, inc_pc;
  logic          mdr_in, mdr_read, mdr_out, zhi_out, zlo_out;
  logic [W-1:0]  mdatain;
  logic [4:0]    alu_op;
  logic          alu_start, alu_busy, alu_done, bus_err;
  logic [W-1:0]  bus;
  logic [2*W-1:0] z;

  int n_chk = 0;
  int n_bad = 0;

  param_datapath_md #(.DATA_W(W), .NREGS(N)) dut (
    .clk(clk), .clr(clr), .rf_in(rf_in), .rf_out(rf_out), .ba_out(ba_out),
    .pc_in(pc_in), .pc_out(pc_out), .hi_in(hi_in), .hi_out(hi_out),
    .lo_in(lo_in), .lo_out(lo_out), .y_in(y_in), .inc_pc(inc_pc),
    .mdr_in(mdr_in), .mdr_read(mdr_read), .mdr_out(mdr_out),
    .zhi_out(zhi_out), .zlo_out(zlo_out), .mdatain(mdatain),
    .alu_op(alu_op), .alu_start(alu_start), .alu_busy(alu_busy),
    .alu_done(alu_done), .bus(bus), .bus_err(bus_err), .z(z)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ctl;
    rf_in = '0; rf_out = '0; ba_out = 0; pc_in = 0; pc_out = 0; hi_in = 0; hi_out = 0;
    lo_in = 0; lo_out = 0; y_in = 0; inc_pc = 0; mdr_in = 0; mdr_read = 0; mdr_out = 0;
    zhi_out = 0; zlo_out = 0; mdatain = '0; alu_op = '0; alu_start = 0;
  endtask

  task automatic mdr_load(input logic [W-1:0] v);
    mdr_in = 1; mdr_read = 1; mdatain = v;
    tick;
    mdr_in = 0; mdr_read = 0;
  endtask

  task automatic put_reg(input int idx, input logic [W-1:0] v);
    mdr_load(v);
    mdr_out = 1; rf_in[idx] = 1;
    tick;
    mdr_out = 0; rf_in = '0;
  endtask

  task automatic put_y(input logic [W-1:0] v);
    mdr_load(v);
    mdr_out = 1; y_in = 1;
    tick;
    mdr_out = 0; y_in = 0;
  endtask

  // lat = edges after the start edge until done is seen (0 = done right after start)
  task automatic run_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat);
    put_y(a);
    mdr_load(b);
    mdr_out = 1; alu_op = op; alu_start = 1;
    tick;
    alu_start = 0; mdr_out = 0; alu_op = 5'h1F;
    lat = 0;
    while (!alu_done && lat < 100) begin
      tick;
      lat++;
    end
  endtask

  function automatic logic [63:0] model(input logic [4:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b, input logic [63:0] zp);
    logic [W-1:0] r;
    logic [63:0]  dbl;
    longint       sa, sb, q, m;
    int           s;
    s  = int'(b[4:0]);
    sa = $signed(a);
    sb = $signed(b);
    r  = '0;
    case (op)
      5'h00: r = a + b;
      5'h01: r = a - b;
      5'h02: r = a & b;
      5'h03: r = a | b;
      5'h04: r = a >> s;
      5'h05: r = $signed(a) >>> s;
      5'h06: r = a << s;
      5'h07: begin dbl = {a, a} >> s; r = dbl[31:0];  end
      5'h08: begin dbl = {a, a} << s; r = dbl[63:32]; end
      5'h09: r = -b;
      5'h0A: r = ~b;
      5'h0B: return sa * sb;
      5'h0C: begin
        if (b == '0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        m = sa % sb;
        return {m[31:0], q[31:0]};
      end
      default: return zp;
    endcase
    return {{32{r[31]}}, r};
  endfunction

  function automatic int exp_lat(input logic [4:0] op, input logic [W-1:0] b);
    return (op == 5'h0B || (op == 5'h0C && b != '0)) ? W + 1 : 0;
  endfunction

  initial begin
    int          lat, cyc, busy_cnt, pulses;
    logic [4:0]  op;
    logic [W-1:0] a, b;
    logic [63:0] exp_z;

    idle_ctl;
    clr = 0;
    tick; tick;
    clr = 1;
    check("init_z", z, 64'h0);
    check("init_busy", alu_busy, 0);
    check("init_done", alu_done, 0);

    // reset clears registers and Z
    put_reg(3, 5);
    rf_out[3] = 1; #1;
    check("r3_loaded", bus, 5);
    rf_out = '0;
    run_op(5'h00, 1, 2, lat);
    check("pre_rst_z", z, 3);
    clr = 0; tick; clr = 1;
    rf_out[3] = 1; #1;
    check("rst_r3", bus, 0);
    rf_out = '0;
    check("rst_z", z, 0);
    check("rst_busy", alu_busy, 0);
    check("rst_done", alu_done, 0);

    // add 7 + R2(9)
    put_reg(2, 9);
    put_y(7);
    rf_out[2] = 1; alu_op = 5'h00; alu_start = 1;
    tick;
    alu_start = 0; rf_out = '0;
    check("add_done", alu_done, 1);
    check("add_z", z, 16);
    zlo_out = 1; #1;
    check("add_zlo_bus", bus, 16);
    tick;
    zlo_out = 0;
    check("add_done_drop", alu_done, 0);

    // mul -3 * 1000 with a second start mid-run and bus/op changing
    put_y(32'hFFFF_FFFD);
    mdr_load(1000);
    mdr_out = 1; alu_op = 5'h0B; alu_start = 1;
    tick;
    alu_start = 0; mdr_out = 0; rf_out[2] = 1; alu_op = 5'h00;
    cyc = 0; busy_cnt = 0;
    while (!alu_done && cyc < 100) begin
      if (alu_busy) busy_cnt++;
      alu_start = (cyc == 5);
      tick;
      cyc++;
    end
    alu_start = 0; rf_out = '0;
    check("mul_z", z, 64'hFFFF_FFFF_FFFF_F448);
    check("mul_busy_cycles", busy_cnt, W + 1);
    check("mul_busy_at_done", alu_busy, 0);
    tick;
    check("mul_done_drop", alu_done, 0);
    check("mul_restart_ignored", alu_busy, 0);

    // div
    run_op(5'h0C, 32'hFFFF_FFF9, 2, lat);
    check("div_z", z, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    check("div_lat", lat, W + 1);
    run_op(5'h0C, 32'hFFFF_FFF9, 0, lat);
    check("div0_z", z, {32'hFFFF_FFF9, 32'hFFFF_FFFF});
    check("div0_lat", lat, 0);
    check("div0_busy", alu_busy, 0);
    run_op(5'h0C, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    check("div_ovf_z", z, {32'h0, 32'h8000_0000});

    // undefined opcode leaves Z
    run_op(5'h15, 3, 4, lat);
    check("undef_z", z, {32'h0, 32'h8000_0000});
    check("undef_lat", lat, 0);

    // bus arbitration
    put_reg(1, 32'h11);
    rf_out[1] = 1; #1;
    check("single_src_err", bus_err, 0);
    pc_out = 1; #1;
    check("multi_src_bus", bus, 0);
    check("multi_src_err", bus_err, 1);
    rf_out = '0; pc_out = 0; #1;
    check("no_src_bus", bus, 0);
    put_reg(0, 32'hAA);
    rf_out[0] = 1; #1;
    check("r0_bus", bus, 32'hAA);
    ba_out = 1; #1;
    check("ba_out_bus", bus, 0);
    check("ba_out_err", bus_err, 0);
    rf_out = '0; ba_out = 0;

    // HI/LO and MDR-from-bus
    put_reg(7, 32'h1234_5678);
    rf_out[7] = 1; hi_in = 1; mdr_in = 1;
    tick;
    rf_out = '0; hi_in = 0; mdr_in = 0;
    hi_out = 1; #1;
    check("hi_bus", bus, 32'h1234_5678);
    hi_out = 0; mdr_out = 1; #1;
    check("mdr_from_bus", bus, 32'h1234_5678);
    lo_in = 1;
    tick;
    mdr_out = 0; lo_in = 0; lo_out = 1; #1;
    check("lo_bus", bus, 32'h1234_5678);
    lo_out = 0;

    // PC priority, wrap and same-edge source/sink
    mdr_load(32'hFFFF_FFFF);
    mdr_out = 1; pc_in = 1; inc_pc = 1;
    tick;
    mdr_out = 0; pc_in = 0;
    pc_out = 1; #1;
    check("pc_in_prio", bus, 32'hFFFF_FFFF);
    pc_out = 0;
    tick;
    inc_pc = 0; pc_out = 1; #1;
    check("pc_wrap", bus, 0);
    inc_pc = 1; rf_in[6] = 1;
    tick;
    inc_pc = 0; rf_in = '0; pc_out = 0;
    rf_out[6] = 1; #1;
    check("collide_r6_old", bus, 0);
    rf_out = '0; pc_out = 1; #1;
    check("collide_pc_new", bus, 1);
    pc_out = 0;

    // abort a multiply by reset mid-run
    put_y(9);
    mdr_load(9);
    mdr_out = 1; alu_op = 5'h0B; alu_start = 1;
    tick;
    alu_start = 0; mdr_out = 0;
    repeat (10) tick;
    check("abort_busy_before", alu_busy, 1);
    clr = 0; tick; clr = 1;
    check("abort_busy", alu_busy, 0);
    check("abort_done", alu_done, 0);
    check("abort_z", z, 0);
    pulses = 0;
    repeat (40) begin
      tick;
      if (alu_done) pulses++;
    end
    check("abort_no_done", pulses, 0);
    run_op(5'h0B, 5, 32'hFFFF_FFFA, lat);
    check("post_abort_mul_z", z, 64'hFFFF_FFFF_FFFF_FFE2);
    check("post_abort_mul_lat", lat, W + 1);

    // randomized ops against the model
    exp_z = 64'hFFFF_FFFF_FFFF_FFE2;
    for (int it = 0; it < 40; it++) begin
      op = 5'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(0, 40));
        default: ;
      endcase
      exp_z = model(op, a, b, exp_z);
      run_op(op, a, b, lat);
      check($sformatf("rnd%0d_op%0h_z", it, op), z, exp_z);
      check($sformatf("rnd%0d_op%0h_lat", it, op), lat, exp_lat(op, b));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
